// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_ROR = 2'b10,
        SHIFT_SRA = 2'b11
    } shift_op_e;

    // Barrel levels handled by each register stage: ceil(log2(width) / stages).
    function automatic int levels_per_stage(input int width, input int stages);
        return ($clog2(width) + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/shift_level.sv
// One barrel level: shifts or rotates right/left by 2**LEVEL when enabled.
// Latency: combinational.
// Backpressure: none; the owning pipeline stage holds its inputs.
module shift_level
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEVEL = 0
) (
    input  logic [WIDTH-1:0] data,
    input  logic             enable,
    input  shift_op_e        op,
    input  logic             sign,
    output logic [WIDTH-1:0] result
);

    localparam int DIST = 1 << LEVEL;

    always_comb begin
        result = data;
        if (enable) begin
            case (op)
                SHIFT_SLL: result = data << DIST;
                SHIFT_SRL: result = data >> DIST;
                // sign comes from the original operand, not this level's MSB
                SHIFT_SRA: result = {{DIST{sign}}, data[WIDTH-1:DIST]};
                SHIFT_ROR: result = {data[DIST-1:0], data[WIDTH-1:DIST]};
                default:   result = data;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined SLL/SRL/SRA/ROR shifter with barrel levels spread over STAGES registers.
// Latency: STAGES cycles from accepted input to out_valid; one op per cycle sustained.
// Backpressure: global stall; in_ready = !out_valid || out_ready, all stages hold when low.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STAGES  = 2,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int NUM_LEVELS = SHAMT_W;
    localparam int PER_STAGE  = levels_per_stage(WIDTH, STAGES);

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Amount is taken mod WIDTH, so the high shamt bits are intentionally dropped.
    logic unused_shamt_hi;
    assign unused_shamt_hi = ^in_shamt[WIDTH-1:SHAMT_W];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0]   src_dat;
        logic               src_vld;
        shift_op_e          src_op;
        logic               src_sign;
        logic [SHAMT_W-1:0] src_shamt;

        logic [WIDTH-1:0]   chain [PER_STAGE+1];

        logic [WIDTH-1:0]   q_dat;
        logic               q_vld;
        shift_op_e          q_op;
        logic               q_sign;
        logic [SHAMT_W-1:0] q_shamt;

        if (k == 0) begin : g_head
            assign src_dat   = in_data;
            assign src_vld   = in_valid;
            assign src_op    = shift_op_e'(in_op);
            assign src_sign  = in_data[WIDTH-1];
            assign src_shamt = in_shamt[SHAMT_W-1:0];
        end else begin : g_body
            assign src_dat   = g_stage[k-1].q_dat;
            assign src_vld   = g_stage[k-1].q_vld;
            assign src_op    = g_stage[k-1].q_op;
            assign src_sign  = g_stage[k-1].q_sign;
            assign src_shamt = g_stage[k-1].q_shamt;
        end

        assign chain[0] = src_dat;

        for (genvar j = 0; j < PER_STAGE; j++) begin : g_lvl
            localparam int LVL = k * PER_STAGE + j;
            if (LVL < NUM_LEVELS) begin : g_shift
                shift_level #(
                    .WIDTH (WIDTH),
                    .LEVEL (LVL)
                ) u_level (
                    .data   (chain[j]),
                    .enable (src_shamt[LVL]),
                    .op     (src_op),
                    .sign   (src_sign),
                    .result (chain[j+1])
                );
            end else begin : g_pass
                assign chain[j+1] = chain[j];
            end
        end

        // Each stage consumes only its own shamt bits; the tail stage's control fields go unread.
        logic unused_fields;
        assign unused_fields = ^{src_shamt, q_op, q_sign, q_shamt};

        always_ff @(posedge clk) begin
            if (reset) begin
                q_vld   <= 1'b0;
                q_dat   <= '0;
                q_op    <= SHIFT_SLL;
                q_sign  <= 1'b0;
                q_shamt <= '0;
            end else if (en) begin
                q_vld   <= src_vld;
                q_dat   <= chain[PER_STAGE];
                q_op    <= src_op;
                q_sign  <= src_sign;
                q_shamt <= src_shamt;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].q_vld;
    assign out_data  = g_stage[STAGES-1].q_dat;

endmodule
